multi_mode_ff_bank: RTL and testbench

- Parametrised bank of WIDTH edge-triggered storage bits; one shared run-time mode makes every bit behave as a D, T, JK or SR flip-flop.
- Generalises the single-bit SR flip-flop:
  - SR S=R=1 becomes a defined, parameter-selected policy instead of undefined behaviour.
  - Illegal-input events are flagged and counted for debug visibility.
- Used as the generic state-register primitive in the flip-flop library and its demo benches.

---
 rtl/multi_mode_ff_bank_pkg.sv | 15 +
 rtl/multi_mode_ff_bank_ff_cell.sv | 68 ++++++
 rtl/multi_mode_ff_bank.sv | 70 +++++++
 tb/tb_multi_mode_ff_bank.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_mode_ff_bank_pkg.sv
// Shared constants for the multi-mode flip-flop bank.
// Mode encodings and SR both-asserted policy codes.
package multi_mode_ff_bank_pkg;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  localparam int POL_HOLD = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;
  localparam int POL_TGL  = 3;

endpackage

// File: rtl/multi_mode_ff_bank_ff_cell.sv
// One storage bit: D/T/JK/SR next-state, async-reset register.
// Ports: clk, rst_n, en, mode, a, b -> q, ill (comb S=R=1 flag).
module ff_cell
  import multi_mode_ff_bank_pkg::*;
#(
  parameter logic RST_VAL = 1'b0,
  parameter int   POLICY  = POL_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       q,
  output logic       ill
);

  logic r_q;
  logic w_nxt;
  logic w_both;

  always_comb begin
    w_both = r_q;
    case (POLICY)
      POL_SET: w_both = 1'b1;
      POL_RST: w_both = 1'b0;
      POL_TGL: w_both = ~r_q;
      default: w_both = r_q;
    endcase
  end

  always_comb begin
    w_nxt = r_q;
    unique case (mode)
      MODE_D:  w_nxt = a;
      MODE_T:  w_nxt = r_q ^ a;
      MODE_JK: begin
        unique case ({a, b})
          2'b00: w_nxt = r_q;
          2'b01: w_nxt = 1'b0;
          2'b10: w_nxt = 1'b1;
          2'b11: w_nxt = ~r_q;
        endcase
      end
      MODE_SR: begin
        unique case ({a, b})
          2'b00: w_nxt = r_q;
          2'b01: w_nxt = 1'b0;
          2'b10: w_nxt = 1'b1;
          2'b11: w_nxt = w_both;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (en) begin
      r_q <= w_nxt;
    end
  end

  assign q   = r_q;
  assign ill = en & (mode == MODE_SR) & a & b;

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit bank of run-time selectable D/T/JK/SR flip-flops.
// Ports: clk, rst_n, en, mode, a, b, clr_cnt -> Q, Q_bar, illegal, illegal_cnt.
module multi_mode_ff_bank
  import multi_mode_ff_bank_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] RST_VAL        = '0,
  parameter int               SR_BOTH_POLICY = POL_HOLD,
  parameter int               CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_ill;
  logic             w_any_ill;
  logic             r_ill;
  logic [CNT_W-1:0] r_cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RST_VAL (RST_VAL[i]),
      .POLICY  (SR_BOTH_POLICY)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .a     (a[i]),
      .b     (b[i]),
      .q     (w_q[i]),
      .ill   (w_ill[i])
    );
  end

  // One event per cycle regardless of how many bits collide.
  assign w_any_ill = |w_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_ill <= w_any_ill;
      if (clr_cnt) begin
        r_cnt <= '0;
      end else if (w_any_ill && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign Q           = w_q;
  assign Q_bar       = ~w_q;
  assign illegal     = r_ill;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Self-checking bench: directed plan plus random stimulus vs model.
// Two DUTs share stimulus: SR policy hold (0) and toggle (3).
module tb_multi_mode_ff_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] a;
  logic [3:0] b;
  logic       clr_cnt;

  logic [3:0] q0, qb0, q3, qb3;
  logic       ill0, ill3;
  logic [1:0] cnt0, cnt3;

  int total = 0;
  int bad   = 0;

  logic [3:0] mq0, mq3;
  logic       mill;
  int         mcnt;

  multi_mode_ff_bank #(
    .WIDTH(4), .RST_VAL(4'b0000),
    .SR_BOTH_POLICY(0), .CNT_W(2)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .mode(mode), .a(a), .b(b),
    .clr_cnt(clr_cnt), .Q(q0), .Q_bar(qb0),
    .illegal(ill0), .illegal_cnt(cnt0)
  );

  multi_mode_ff_bank #(
    .WIDTH(4), .RST_VAL(4'b0000),
    .SR_BOTH_POLICY(3), .CNT_W(2)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .mode(mode), .a(a), .b(b),
    .clr_cnt(clr_cnt), .Q(q3), .Q_bar(qb3),
    .illegal(ill3), .illegal_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_next(
    input logic [3:0] q, input logic [1:0] m,
    input logic [3:0] s, input logic [3:0] r,
    input int pol);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      if (m == 2'd0) n[i] = s[i];
      else if (m == 2'd1) n[i] = q[i] ^ s[i];
      else if (s[i] && r[i]) begin
        if (m == 2'd2) n[i] = ~q[i];
        else if (pol == 1) n[i] = 1'b1;
        else if (pol == 2) n[i] = 1'b0;
        else if (pol == 3) n[i] = ~q[i];
        else n[i] = q[i];
      end
      else if (s[i]) n[i] = 1'b1;
      else if (r[i]) n[i] = 1'b0;
      else n[i] = q[i];
    end
    return n;
  endfunction

  task automatic model_reset();
    mq0  = 4'b0000;
    mq3  = 4'b0000;
    mill = 1'b0;
    mcnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q0"},   {28'd0, q0},   {28'd0, mq0});
    chk({tag, ".qb0"},  {28'd0, qb0},  {28'd0, ~mq0});
    chk({tag, ".q3"},   {28'd0, q3},   {28'd0, mq3});
    chk({tag, ".qb3"},  {28'd0, qb3},  {28'd0, ~mq3});
    chk({tag, ".ill"},  {31'd0, ill0}, {31'd0, mill});
    chk({tag, ".ill3"}, {31'd0, ill3}, {31'd0, mill});
    chk({tag, ".cnt"},  {30'd0, cnt0}, mcnt);
    chk({tag, ".cnt3"}, {30'd0, cnt3}, mcnt);
  endtask

  task automatic cyc(input string tag);
    logic ev;
    @(posedge clk);
    if (rst_n) begin
      ev = en && (mode == 2'b11) && ((a & b) != 4'b0);
      if (en) begin
        mq0 = ref_next(mq0, mode, a, b, 0);
        mq3 = ref_next(mq3, mode, a, b, 3);
      end
      mill = ev;
      if (clr_cnt) mcnt = 0;
      else if (ev && mcnt < 3) mcnt = mcnt + 1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic e, input logic [1:0] m,
                       input logic [3:0] s, input logic [3:0] r,
                       input logic c);
    en = e; mode = m; a = s; b = r; clr_cnt = c;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 4'b0, 4'b0, 1'b0);
    model_reset();
    #12;
    check_all("rst");
    chk("rst.qb_const", {28'd0, qb0}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 2'b00, 4'b1010, 4'b0000, 1'b0);
    cyc("d");
    chk("d.q_const", {28'd0, q0}, 32'hA);
    drive(1'b0, 2'b00, 4'b0101, 4'b0000, 1'b0);
    cyc("hold");
    chk("hold.q_const", {28'd0, q0}, 32'hA);

    drive(1'b1, 2'b01, 4'b0011, 4'b0000, 1'b0);
    cyc("t1");
    chk("t1.q_const", {28'd0, q0}, 32'h9);
    cyc("t2");
    chk("t2.q_const", {28'd0, q0}, 32'hA);

    drive(1'b1, 2'b10, 4'b1100, 4'b0110, 1'b0);
    cyc("jk");
    chk("jk.q_const", {28'd0, q0}, 32'hC);
    drive(1'b1, 2'b10, 4'b1111, 4'b1111, 1'b0);
    cyc("jk11");
    chk("jk11.noill", {31'd0, ill0}, 32'd0);
    drive(1'b1, 2'b10, 4'b1100, 4'b0110, 1'b0);
    cyc("jk2");
    drive(1'b1, 2'b00, 4'b1100, 4'b0000, 1'b0);
    cyc("dfix");

    drive(1'b1, 2'b11, 4'b0011, 4'b0001, 1'b0);
    cyc("sr");
    chk("sr.q0_const", {28'd0, q0}, 32'hE);
    chk("sr.q3_const", {28'd0, q3}, 32'hF);
    chk("sr.ill_const", {31'd0, ill0}, 32'd1);
    drive(1'b1, 2'b11, 4'b0000, 4'b0000, 1'b1);
    cyc("srclr");
    chk("srclr.ill_const", {31'd0, ill0}, 32'd0);

    drive(1'b1, 2'b11, 4'b1000, 4'b1000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc("sat");
      chk("sat.ill_const", {31'd0, ill0}, 32'd1);
    end
    chk("sat.cnt_const", {30'd0, cnt0}, 32'd3);
    drive(1'b1, 2'b11, 4'b1000, 4'b1000, 1'b1);
    cyc("clrwin");
    chk("clrwin.cnt_const", {30'd0, cnt0}, 32'd0);
    chk("clrwin.ill_const", {31'd0, ill0}, 32'd1);
    drive(1'b1, 2'b11, 4'b0110, 4'b0010, 1'b0);
    cyc("pre_rst");

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'b11, 4'b0101, 4'b0000, 1'b0);
    cyc("resume");
    chk("resume.q_const", {28'd0, q0}, 32'h5);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 7) != 0,
            2'($urandom_range(0, 3)),
            4'($urandom), 4'($urandom),
            $urandom_range(0, 9) == 0);
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
